// File: rtl/perfil_pkg.sv
// Shared profile codes and session FSM state encoding.
package perfil_pkg;

    localparam int unsigned PERFIL_GUEST  = 0;
    localparam int unsigned PERFIL_USER   = 1;
    localparam int unsigned PERFIL_TESTER = 2;
    localparam int unsigned PERFIL_ADM    = 3;

    typedef enum logic [1:0] {
        OCIOSO,
        ATIVA,
        BLOQUEADO
    } estado_t;

endpackage

// File: rtl/codificador_perfil_onehot.sv
// One-hot profile select encoder: code = set bit index + 1, 0 when all-zero;
// valido drops when more than one select line is high.
module codificador_perfil_onehot #(
    parameter int unsigned N_PERFIS = 4
) (
    input  logic [N_PERFIS-2:0]         sel,
    output logic [$clog2(N_PERFIS)-1:0] code,
    output logic                        valido
);

    localparam int unsigned W = $clog2(N_PERFIS);

    logic found;

    always_comb begin
        code   = '0;
        valido = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < int'(N_PERFIS) - 1; i++) begin
            if (sel[i]) begin
                if (found) begin
                    valido = 1'b0;
                end
                found = 1'b1;
                code  = W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/gerenciador_perfil_sessao.sv
// Session/profile manager: latches the encoded profile on login, closes on logout
// or idle timeout. Optional lockout after repeated rejected logins under LOCKOUT_EN.
module gerenciador_perfil_sessao
    import perfil_pkg::*;
#(
    parameter int unsigned N_PERFIS   = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned MAX_FALHAS = 3,
    parameter int unsigned BLOQUEIO   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PERFIS-2:0]         sel,
    input  logic                        login,
    input  logic                        logout,
    input  logic                        atividade,
    output logic [$clog2(N_PERFIS)-1:0] perfil,
    output logic                        sessao_ativa,
    output logic                        erro,
    output logic                        expirou,
    output logic                        bloqueado
);

    localparam int unsigned W  = $clog2(N_PERFIS);
    localparam int unsigned IW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

    estado_t         state, state_n;
    logic [IW-1:0]   idle, idle_n, idle_sat;
    logic [W-1:0]    perfil_n, code;
    logic            valido, erro_n, expirou_n;
    logic            falha, sucesso;

`ifdef LOCKOUT_EN
    localparam int unsigned FW = $clog2(MAX_FALHAS + 1);
    localparam int unsigned LW = $clog2(BLOQUEIO);
    localparam logic [LW-1:0] LOCK_MAX = LW'(BLOQUEIO - 1);

    logic [FW-1:0] falhas, falhas_n;
    logic [LW-1:0] lock_cnt, lock_n;
`else
    logic unused_cfg;
    assign unused_cfg = ^{falha, sucesso, 32'(MAX_FALHAS), 32'(BLOQUEIO)};
    assign bloqueado  = 1'b0;
`endif

    codificador_perfil_onehot #(.N_PERFIS(N_PERFIS)) u_cod (
        .sel    (sel),
        .code   (code),
        .valido (valido)
    );

    // Stops at IDLE_MAX so the counter can never wrap
    assign idle_sat = (idle == IDLE_MAX) ? idle : idle + IW'(1);

    always_comb begin
        state_n   = state;
        idle_n    = idle;
        perfil_n  = perfil;
        erro_n    = 1'b0;
        expirou_n = 1'b0;
        falha     = 1'b0;
        sucesso   = 1'b0;
`ifdef LOCKOUT_EN
        falhas_n  = falhas;
        lock_n    = lock_cnt;
`endif
        case (state)
            OCIOSO: begin
                if (login && valido) begin
                    state_n  = ATIVA;
                    perfil_n = code;
                    idle_n   = '0;
                    sucesso  = 1'b1;
                end else if (login) begin
                    erro_n = 1'b1;
                    falha  = 1'b1;
                end
            end
            ATIVA: begin
                if (logout) begin
                    state_n  = OCIOSO;
                    perfil_n = W'(PERFIL_GUEST);
                    idle_n   = '0;
                end else if (login && valido) begin
                    perfil_n = code;
                    idle_n   = '0;
                    sucesso  = 1'b1;
                end else if (login) begin
                    erro_n = 1'b1;
                    falha  = 1'b1;
                    idle_n = atividade ? '0 : idle_sat;
                end else if (atividade) begin
                    idle_n = '0;
                end else if (idle == IDLE_MAX) begin
                    state_n   = OCIOSO;
                    perfil_n  = W'(PERFIL_GUEST);
                    idle_n    = '0;
                    expirou_n = 1'b1;
                end else begin
                    idle_n = idle_sat;
                end
            end
            BLOQUEADO: begin
`ifdef LOCKOUT_EN
                if (lock_cnt == LOCK_MAX) begin
                    state_n  = OCIOSO;
                    falhas_n = '0;
                end else begin
                    lock_n = lock_cnt + LW'(1);
                end
`else
                state_n = OCIOSO;
`endif
            end
            default: state_n = OCIOSO;
        endcase
`ifdef LOCKOUT_EN
        // Rejected logins accumulate; the last allowed one closes any session and locks
        if (sucesso) begin
            falhas_n = '0;
        end else if (falha) begin
            falhas_n = falhas + FW'(1);
            if (falhas == FW'(MAX_FALHAS - 1)) begin
                state_n  = BLOQUEADO;
                perfil_n = W'(PERFIL_GUEST);
                idle_n   = '0;
                lock_n   = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OCIOSO;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle         <= '0;
            perfil       <= '0;
            sessao_ativa <= 1'b0;
            erro         <= 1'b0;
            expirou      <= 1'b0;
        end else begin
            idle         <= idle_n;
            perfil       <= perfil_n;
            sessao_ativa <= (state_n == ATIVA);
            erro         <= erro_n;
            expirou      <= expirou_n;
        end
    end

`ifdef LOCKOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            falhas    <= '0;
            lock_cnt  <= '0;
            bloqueado <= 1'b0;
        end else begin
            falhas    <= falhas_n;
            lock_cnt  <= lock_n;
            bloqueado <= (state_n == BLOQUEADO);
        end
    end
`endif

endmodule

// File: tb/tb_gerenciador_perfil_sessao.sv
// Directed bench for gerenciador_perfil_sessao with an expected-output queue;
// lockout steps run only when LOCKOUT_EN is defined.
module tb_gerenciador_perfil_sessao;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sel;
    logic       login, logout, atividade;
    logic [1:0] perfil;
    logic       sessao_ativa, erro, expirou, bloqueado;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [5:0] fila[$];

    gerenciador_perfil_sessao #(
        .N_PERFIS   (4),
        .TIMEOUT    (8),
        .MAX_FALHAS (3),
        .BLOQUEIO   (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sel          (sel),
        .login        (login),
        .logout       (logout),
        .atividade    (atividade),
        .perfil       (perfil),
        .sessao_ativa (sessao_ativa),
        .erro         (erro),
        .expirou      (expirou),
        .bloqueado    (bloqueado)
    );

    always #5 clk = ~clk;

    // {perfil, sessao_ativa, erro, expirou, bloqueado}
    function automatic logic [5:0] ex(input logic [1:0] p, input logic sa, input logic er,
                                      input logic xp, input logic bl);
        return {p, sa, er, xp, bl};
    endfunction

    task automatic compare(input string tag);
        logic [5:0] obs;
        logic [5:0] exv;
        obs = {perfil, sessao_ativa, erro, expirou, bloqueado};
        if (fila.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            exv = fila.pop_front();
            total++;
            assert (obs === exv) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exv);
            end
        end
    endtask

    task automatic cyc(input logic l, input logic [2:0] s, input logic lo, input logic at,
                       input string tag, input logic [5:0] exv);
        login     = l;
        sel       = s;
        logout    = lo;
        atividade = at;
        fila.push_back(exv);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sel = '0; login = 0; logout = 0; atividade = 0;
        #12;
        fila.push_back(ex(0, 0, 0, 0, 0));
        compare("reset_state");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Login with ADM, then switch profile, then logout beating a login
        cyc(1, 3'b100, 0, 0, "login_adm",       ex(3, 1, 0, 0, 0));
        cyc(1, 3'b001, 0, 0, "switch_user",     ex(1, 1, 0, 0, 0));
        cyc(1, 3'b010, 1, 0, "logout_wins",     ex(0, 0, 0, 0, 0));

        // Multi-hot rejections in OCIOSO and in ATIVA
        cyc(1, 3'b110, 0, 0, "reject_ocioso",   ex(0, 0, 1, 0, 0));
        cyc(0, 3'b000, 0, 0, "erro_one_cycle",  ex(0, 0, 0, 0, 0));
        cyc(1, 3'b010, 0, 0, "login_tester",    ex(2, 1, 0, 0, 0));
        cyc(1, 3'b011, 0, 0, "reject_ativa",    ex(2, 1, 1, 0, 0));
        cyc(0, 3'b000, 0, 0, "ativa_kept",      ex(2, 1, 0, 0, 0));
        cyc(0, 3'b000, 1, 0, "logout",          ex(0, 0, 0, 0, 0));
        cyc(0, 3'b000, 1, 1, "ignored_ocioso",  ex(0, 0, 0, 0, 0));
        cyc(1, 3'b000, 0, 0, "login_guest",     ex(0, 1, 0, 0, 0));
        cyc(0, 3'b000, 1, 0, "logout_guest",    ex(0, 0, 0, 0, 0));

        // Timeout: 7 idle cycles keep the session, the 8th closes it
        cyc(1, 3'b001, 0, 0, "login_to",        ex(1, 1, 0, 0, 0));
        for (int k = 1; k < 8; k++) cyc(0, 3'b000, 0, 0, "idle_hold", ex(1, 1, 0, 0, 0));
        cyc(0, 3'b000, 0, 0, "expirou",         ex(0, 0, 0, 1, 0));
        cyc(0, 3'b000, 0, 0, "expirou_pulse",   ex(0, 0, 0, 0, 0));

        // Activity at the last idle cycle rescues the session
        cyc(1, 3'b100, 0, 0, "login_edge",      ex(3, 1, 0, 0, 0));
        for (int k = 1; k < 8; k++) cyc(0, 3'b000, 0, 0, "edge_hold", ex(3, 1, 0, 0, 0));
        cyc(0, 3'b000, 0, 1, "edge_rescue",     ex(3, 1, 0, 0, 0));
        for (int k = 1; k < 8; k++) cyc(0, 3'b000, 0, 0, "edge_hold2", ex(3, 1, 0, 0, 0));
        cyc(0, 3'b000, 0, 0, "edge_expirou",    ex(0, 0, 0, 1, 0));

        // Periodic activity keeps the session open
        cyc(1, 3'b010, 0, 0, "login_keep",      ex(2, 1, 0, 0, 0));
        for (int j = 1; j <= 20; j++) cyc(0, 3'b000, 0, (j % 5) == 0, "keepalive", ex(2, 1, 0, 0, 0));
        cyc(0, 3'b000, 1, 0, "logout_keep",     ex(0, 0, 0, 0, 0));

`ifdef LOCKOUT_EN
        cyc(1, 3'b110, 0, 0, "fail1",           ex(0, 0, 1, 0, 0));
        cyc(1, 3'b101, 0, 0, "fail2",           ex(0, 0, 1, 0, 0));
        cyc(1, 3'b111, 0, 0, "lock_enter",      ex(0, 0, 1, 0, 1));
        for (int j = 1; j < 32; j++) cyc(j == 5 || j == 31, 3'b001, j == 9, 0, "locked", ex(0, 0, 0, 0, 1));
        cyc(0, 3'b000, 0, 0, "lock_exit",       ex(0, 0, 0, 0, 0));
        cyc(1, 3'b010, 0, 0, "login_after",     ex(2, 1, 0, 0, 0));
        cyc(0, 3'b000, 1, 0, "logout_after",    ex(0, 0, 0, 0, 0));
`endif

        // Async reset mid-session clears outputs without an expirou pulse
        cyc(1, 3'b001, 0, 0, "login_rst",       ex(1, 1, 0, 0, 0));
        for (int k = 1; k < 7; k++) cyc(0, 3'b000, 0, 0, "pre_rst", ex(1, 1, 0, 0, 0));
        #2;
        reset = 1'b1;
        #1;
        fila.push_back(ex(0, 0, 0, 0, 0));
        compare("async_reset");
        @(posedge clk);
        #1;
        fila.push_back(ex(0, 0, 0, 0, 0));
        compare("reset_held");
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 3'b000, 0, 0, "after_reset",     ex(0, 0, 0, 0, 0));
        cyc(1, 3'b100, 0, 0, "relogin",         ex(3, 1, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
